// File: rtl/bayer_gray_source_pkg.sv
// bayer_gray_pkg: shared state type and datapath widths for the Bayer 2x2 gray binner
package bayer_gray_pkg;
  typedef enum logic [1:0] {S_WAIT_SOF, S_FILL, S_EMIT} bg_state_t;
  localparam int PIX_W  = 12;
  localparam int PAIR_W = 13;
  localparam int SUM_W  = 14;
endpackage

// File: rtl/bayer_gray_source_if.sv
// bayer_gray_source_if: raw Bayer input stream and binned gray output stream
interface bayer_gray_source_if;
  import bayer_gray_pkg::*;
  logic             iDVAL;
  logic [PIX_W-1:0] iDATA;
  logic [15:0]      iX_Cont;
  logic [15:0]      iY_Cont;
  logic             oDVAL;
  logic [PIX_W-1:0] oGRAY;
  logic [9:0]       oX;
  logic [9:0]       oY;
  logic             oSOF;
  modport master (input iDVAL, iDATA, iX_Cont, iY_Cont, output oDVAL, oGRAY, oX, oY, oSOF);
  modport slave (output iDVAL, iDATA, iX_Cont, iY_Cont, input oDVAL, oGRAY, oX, oY, oSOF);
endinterface

// File: rtl/gray_pair_linebuf.sv
// gray_pair_linebuf: simple dual-port RAM holding the even-line pair sums, 1-cycle registered read
module gray_pair_linebuf #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int W     = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/bayer_gray_source.sv
// bayer_gray_source: bins the raw Bayer stream 2x2 -> 1 into a 12-bit gray pixel stream
module bayer_gray_source
  import bayer_gray_pkg::*;
#(
  parameter int RAW_W = 1280,
  parameter int RAW_H = 960
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  bayer_gray_source_if.master bus
);
  localparam int OUT_W = RAW_W / 2;
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  bg_state_t         state_q, state_d, cur;
  logic [PIX_W-1:0]  pair_q, pair_d, gray_q, gray_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              dval_q, dval_d, sof_q, sof_d;
  logic              acc, sof, odd_col, fire, we, re;
  logic [AW-1:0]     addr;
  logic [PAIR_W-1:0] rd_data, wr_data;
  logic [SUM_W-1:0]  sum14;
  // The beat that switches line parity is already processed in the new state
  always_comb begin
    acc     = bus.iDVAL && (bus.iX_Cont < 16'(RAW_W)) && (bus.iY_Cont < 16'(RAW_H));
    sof     = acc && (bus.iX_Cont == '0) && (bus.iY_Cont == '0);
    odd_col = bus.iX_Cont[0];
    addr    = bus.iX_Cont[AW:1];
    cur     = sof ? S_FILL :
              (state_q == S_FILL && bus.iY_Cont[0]) ? S_EMIT :
              (state_q == S_EMIT && !bus.iY_Cont[0]) ? S_FILL : state_q;
    state_d = acc ? cur : state_q;
    fire    = acc && cur == S_EMIT && odd_col;
    we      = acc && cur == S_FILL && odd_col;
    re      = acc && cur == S_EMIT && !odd_col;
    pair_d  = (acc && cur != S_WAIT_SOF && !odd_col) ? bus.iDATA : pair_q;
    wr_data = PAIR_W'(pair_q) + PAIR_W'(bus.iDATA);
    sum14   = SUM_W'(rd_data) + SUM_W'(pair_q) + SUM_W'(bus.iDATA);
    dval_d  = fire;
    gray_d  = fire ? sum14[SUM_W-1:2] : gray_q;
    x_d     = fire ? bus.iX_Cont[10:1] : x_q;
    y_d     = fire ? bus.iY_Cont[10:1] : sof ? '0 : y_q;
    sof_d   = fire && bus.iX_Cont[10:1] == '0 && bus.iY_Cont[10:1] == '0;
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_WAIT_SOF;
      pair_q  <= '0;
      gray_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dval_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      gray_q  <= gray_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dval_q  <= dval_d;
      sof_q   <= sof_d;
    end
  end
  gray_pair_linebuf #(.DEPTH(OUT_W), .AW(AW), .W(PAIR_W)) u_linebuf (
    .clk   (iCLK),
    .we    (we),
    .waddr (addr),
    .wdata (wr_data),
    .re    (re),
    .raddr (addr),
    .rdata (rd_data)
  );
  assign bus.oDVAL = dval_q;
  assign bus.oGRAY = gray_q;
  assign bus.oX    = x_q;
  assign bus.oY    = y_q;
  assign bus.oSOF  = sof_q;
endmodule

// File: tb/tb_bayer_gray_source.sv
// tb_bayer_gray_source: table, random-frame and hand-sequence checks of the 2x2 gray binner
module tb_bayer_gray_source;
  localparam int RAW_W = 16;
  localparam int RAW_H = 8;
  localparam int OUT_W = RAW_W / 2;
  localparam int OUT_H = RAW_H / 2;
  typedef struct {
    logic [11:0] r, g1, g2, b, gray;
  } vec_t;
  typedef struct {
    logic [11:0] g;
    logic [9:0]  x, y;
    logic        s;
  } exp_t;
  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  bayer_gray_source_if bus();
  bayer_gray_source #(.RAW_W(RAW_W), .RAW_H(RAW_H)) dut (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));
  always #5 iCLK = ~iCLK;
  int n_cmp = 0, n_err = 0;
  int pulses = 0, beats = 0, sofs = 0;
  bit mon_en = 1'b0;
  logic [11:0] frame [RAW_H][RAW_W];
  exp_t exp_q[$];
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask
  task automatic step(input logic v, input logic [11:0] d, input logic [15:0] x, input logic [15:0] y);
    bus.iDVAL = v;
    bus.iDATA = d;
    bus.iX_Cont = x;
    bus.iY_Cont = y;
    @(posedge iCLK);
    #1;
  endtask
  task automatic idle(input logic [15:0] y);
    case ($urandom_range(0, 2))
      0: step(1'b0, 12'($urandom), 16'($urandom_range(0, RAW_W - 1)), y);
      1: step(1'b1, 12'($urandom), 16'($urandom_range(RAW_W, 65535)), y);
      default: step(1'b1, 12'($urandom), 16'($urandom_range(0, RAW_W - 1)), 16'($urandom_range(RAW_H, 65535)));
    endcase
  endtask
  task automatic drive_frame(input bit gaps);
    exp_t e;
    int s;
    beats = 0;
    sofs = 0;
    for (int by = 0; by < OUT_H; by++)
      for (int bx = 0; bx < OUT_W; bx++) begin
        s = int'(frame[2*by][2*bx]) + int'(frame[2*by][2*bx+1]) +
            int'(frame[2*by+1][2*bx]) + int'(frame[2*by+1][2*bx+1]);
        e.g = 12'(s / 4);
        e.x = 10'(bx);
        e.y = 10'(by);
        e.s = (bx == 0 && by == 0);
        exp_q.push_back(e);
      end
    for (int y = 0; y < RAW_H; y++) begin
      for (int x = 0; x < RAW_W; x++) begin
        if (gaps) repeat ($urandom_range(0, 2)) idle(16'(y));
        step(1'b1, frame[y][x], 16'(x), 16'(y));
      end
      if (gaps) idle(16'(y));
    end
    step(1'b0, 12'h0, 16'h0, 16'h0);
    step(1'b0, 12'h0, 16'h0, 16'h0);
    chk("frame_beats", 32'(beats), 32'(OUT_W * OUT_H));
    chk("frame_sofs", 32'(sofs), 32'd1);
    chk("queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask
  always @(negedge iCLK) begin
    if (bus.oDVAL === 1'b1) begin
      exp_t e;
      pulses++;
      beats++;
      if (bus.oSOF === 1'b1) sofs++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: oX=%0d oY=%0d oGRAY=%0h with nothing expected", bus.oX, bus.oY, bus.oGRAY);
        end else begin
          e = exp_q.pop_front();
          chk("gray", 32'(bus.oGRAY), 32'(e.g));
          chk("ox", 32'(bus.oX), 32'(e.x));
          chk("oy", 32'(bus.oY), 32'(e.y));
          chk("osof", 32'(bus.oSOF), 32'(e.s));
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{12'd4, 12'd8, 12'd12, 12'd17, 12'd10};
    tbl[1] = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h800};
    tbl[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    tbl[3] = '{12'd0, 12'd0, 12'd0, 12'd3, 12'd0};
    tbl[4] = '{12'd1, 12'd1, 12'd1, 12'd1, 12'd1};
    tbl[5] = '{12'hFFF, 12'd0, 12'd0, 12'd0, 12'h3FF};
    tbl[6] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd1};
    tbl[7] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'd0, 12'hBFF};
    bus.iDVAL = 1'b0;
    bus.iDATA = '0;
    bus.iX_Cont = '0;
    bus.iY_Cont = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_dval", 32'(bus.oDVAL), 32'd0);
    chk("rst_gray", 32'(bus.oGRAY), 32'd0);
    chk("rst_x", 32'(bus.oX), 32'd0);
    chk("rst_y", 32'(bus.oY), 32'd0);
    chk("rst_sof", 32'(bus.oSOF), 32'd0);
    iRST_N = 1'b1;
    step(1'b0, 12'h0, 16'h0, 16'h0);
    // Block (0,0) = 4/8/12/17, one-cycle latency, gap and junk beats inside a pair
    for (int x = 0; x < RAW_W; x++)
      step(1'b1, (x == 0) ? 12'd4 : (x == 1) ? 12'd8 : 12'd0, 16'(x), 16'd0);
    step(1'b1, 12'd12, 16'd0, 16'd1);
    chk("blk0_early_dval", 32'(bus.oDVAL), 32'd0);
    step(1'b1, 12'd17, 16'd1, 16'd1);
    chk("blk0_dval", 32'(bus.oDVAL), 32'd1);
    chk("blk0_gray", 32'(bus.oGRAY), 32'd10);
    chk("blk0_x", 32'(bus.oX), 32'd0);
    chk("blk0_y", 32'(bus.oY), 32'd0);
    chk("blk0_sof", 32'(bus.oSOF), 32'd1);
    step(1'b1, 12'd0, 16'd2, 16'd1);
    chk("pulse_width", 32'(bus.oDVAL), 32'd0);
    for (int x = 3; x < 6; x++) step(1'b1, 12'd0, 16'(x), 16'd1);
    step(1'b1, 12'd100, 16'd6, 16'd1);
    step(1'b0, 12'hFFF, 16'd7, 16'd1);
    chk("gap_dval0", 32'(bus.oDVAL), 32'd0);
    step(1'b1, 12'hFFF, 16'(RAW_W), 16'd1);
    chk("gap_oob_x", 32'(bus.oDVAL), 32'd0);
    step(1'b1, 12'hFFF, 16'd7, 16'(RAW_H));
    chk("gap_oob_y", 32'(bus.oDVAL), 32'd0);
    step(1'b0, 12'hFFF, 16'd7, 16'd1);
    chk("gap_dval3", 32'(bus.oDVAL), 32'd0);
    step(1'b0, 12'h0, 16'd0, 16'd0);
    chk("gap_dval4", 32'(bus.oDVAL), 32'd0);
    step(1'b1, 12'd200, 16'd7, 16'd1);
    chk("gap_dval", 32'(bus.oDVAL), 32'd1);
    chk("gap_gray", 32'(bus.oGRAY), 32'd75);
    chk("gap_x", 32'(bus.oX), 32'd3);
    chk("gap_sof", 32'(bus.oSOF), 32'd0);
    // Asynchronous reset while emitting, then no output until SOF
    #2 iRST_N = 1'b0;
    #1;
    chk("arst_dval", 32'(bus.oDVAL), 32'd0);
    chk("arst_gray", 32'(bus.oGRAY), 32'd0);
    chk("arst_x", 32'(bus.oX), 32'd0);
    chk("arst_y", 32'(bus.oY), 32'd0);
    chk("arst_sof", 32'(bus.oSOF), 32'd0);
    step(1'b0, 12'h0, 16'h0, 16'h0);
    iRST_N = 1'b1;
    pulses = 0;
    for (int y = 2; y < 4; y++)
      for (int x = 0; x < RAW_W; x++) step(1'b1, 12'($urandom), 16'(x), 16'(y));
    step(1'b0, 12'h0, 16'h0, 16'h0);
    chk("no_beat_without_sof", 32'(pulses), 32'd0);
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int y = 0; y < RAW_H; y++)
        for (int x = 0; x < RAW_W; x++)
          frame[y][x] = (y % 2 == 0) ? ((x % 2 == 0) ? tbl[i].r : tbl[i].g1)
                                     : ((x % 2 == 0) ? tbl[i].g2 : tbl[i].b);
      drive_frame(i[0]);
      chk("tbl_last_gray", 32'(bus.oGRAY), 32'(tbl[i].gray));
    end
    for (int f = 0; f < 4; f++) begin
      for (int y = 0; y < RAW_H; y++)
        for (int x = 0; x < RAW_W; x++) frame[y][x] = 12'($urandom);
      drive_frame(1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
